// File: rtl/down_counter_8_pkg.sv
// Shared constants for the down_counter_8 block.
//   DC_WIDTH : default counter / load-data width in bits.
package down_counter_8_pkg;
  localparam int DC_WIDTH = 8;
endpackage

// File: rtl/down_counter_8.sv
// down_counter_8: loadable synchronous down counter with terminal-count flag.
//   clk     in  1      rising-edge clock
//   rst     in  1      async active-high reset, clears count to 0
//   load    in  1      sync parallel load (wins over enable)
//   enable  in  1      sync decrement, wraps 0 -> all-ones
//   data_in in  WIDTH  load value
//   count   out WIDTH  counter register
//   tc      out 1      1 when count == 0 (combinational, not gated by enable)
module down_counter_8
  import down_counter_8_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_dec;

  // Unsigned subtract wraps naturally, giving 0 -> all-ones.
  assign w_dec = r_count - {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (load)   r_count <= data_in;
    else if (enable) r_count <= w_dec;
  end

  assign count = r_count;
  assign tc    = (r_count == '0);

endmodule

// File: tb/tb_down_counter_8.sv
// Self-checking bench for down_counter_8: directed plan then randomized traffic
// against an arithmetic reference model.
module tb_down_counter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       enable;
  logic [7:0] data_in;
  logic [7:0] count;
  logic       tc;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;   // reference count value, 0..255

  down_counter_8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .enable(enable),
    .data_in(data_in), .count(count), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, want, $time);
    end
  endtask

  // Apply inputs after a falling edge, let one rising edge sample them,
  // advance the model, then check on the next falling edge.
  task automatic step(input logic l, input logic e, input logic [7:0] d);
    load = l; enable = e; data_in = d;
    @(posedge clk);
    if (l)      exp_cnt = int'(d);
    else if (e) exp_cnt = (exp_cnt + 255) % 256;
    @(negedge clk);
    chk("count", int'(count), exp_cnt);
    chk("tc", int'(tc), (exp_cnt == 0) ? 1 : 0);
  endtask

  // Assert reset between edges; count must clear before the next rising edge
  // and stay clear across an edge with load/enable active.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk("rst_async_count", int'(count), 0);
    chk("rst_async_tc", int'(tc), 1);
    load = 1'b1; enable = 1'b1; data_in = 8'h55;
    @(posedge clk); #1;
    chk("rst_hold_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_tc", int'(tc), 1);

    rst = 1'b0;
    step(1'b1, 1'b0, 8'h05);
    chk("load_val", int'(count), 5);
    step(1'b0, 1'b1, 8'h00);
    chk("dec1", int'(count), 4);
    step(1'b0, 1'b1, 8'h00);
    chk("dec2", int'(count), 3);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    chk("tc_zero", int'(tc), 1);
    step(1'b0, 1'b1, 8'h00);
    chk("wrap_ff", int'(count), 8'hFF);
    chk("wrap_tc", int'(tc), 0);
    step(1'b1, 1'b1, 8'hA0);
    chk("load_prio", int'(count), 8'hA0);
    step(1'b0, 1'b0, 8'h33);
    chk("hold", int'(count), 8'hA0);
    step(1'b1, 1'b0, 8'h00);
    chk("load_zero_tc", int'(tc), 1);
    step(1'b1, 1'b0, 8'h40);
    load = 1'b0; enable = 1'b1;
    async_reset_pulse();
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst", int'(count), 0);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic       l, e;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        load = 1'b0; enable = 1'b1;
        async_reset_pulse();
      end else begin
        l = ($urandom_range(0, 99) < 12);
        e = ($urandom_range(0, 99) < 75);
        d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
        step(l, e, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_8.md
Name: down_counter_8

Overview:
- 8-bit loadable, synchronous down counter with a terminal-count flag.
- Used as a generic countdown timer or event counter in control datapaths.
- Supports parallel load, a count-enable, and asynchronous reset to zero.
- tc asserts whenever the count value is zero.

Parameters:
- WIDTH, 8, counter and data_in width in bits. Every value below assumes WIDTH=8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  synchronous parallel-load request.
- enable  input  1  synchronous count-down enable.
- data_in  input  WIDTH  value written into the counter when load=1.
- count  output  WIDTH  current counter value, driven directly from the register.
- tc  output  1  terminal count; 1 exactly when count==0.

Behaviour:
- Reset:
  - rst=1 immediately forces count=0, independent of clk.
  - tc therefore reads 1 during reset.
  - While rst is held high, count stays 0 regardless of load or enable.
  - Release of rst is synchronous in effect: the first update happens on the first rising edge after rst falls.
- Priority on each rising clk edge (rst=0):
  - load=1: count <= data_in. load has priority over enable.
  - else enable=1: count <= count - 1, modulo 2^WIDTH.
  - else: count holds.
- Latency:
  - A load or decrement is visible on count one clock after the edge that samples it; zero cycles of added latency beyond the register.
- Wrap-around:
  - count=0x00 with enable=1 and load=0 gives 0xFF on the next edge.
  - tc deasserts on that same edge.
- Terminal count:
  - tc = (count == 0), purely combinational from the register.
  - No extra pipeline stage.
  - Not gated by enable.
- Loading zero: load with data_in=0x00 gives count=0 and tc=1 on the next edge.
- Simultaneous load and enable: load wins and no decrement occurs in that cycle.
- Reset mid-operation: asynchronously aborts any count or load; count=0 and tc=1 immediately.
- Inputs load, enable and data_in are sampled only on rising clk edges.
- No X propagation from an undriven data_in when load=0.

Decomposition:
- Shared package: none required.
- If the codebase keeps common widths centrally, the default counter width constant (8) may live there.
- Single flat module containing one register and comparator logic. No sub-module is warranted.

Test Plan:
- Reset: rst=1, enable=0, load=0 for 2 cycles -> at the next falling edge count=0x00, tc=1.
- Load:
  - Stimulus: rst=0, data_in=0x05, load=1 for one rising edge, then load=0 and enable=1.
  - Response: at the following falling edge count=0x05, tc=0.
- Countdown: continue with enable=1 -> the next two falling edges show count=0x04 then 0x03, tc=0 on both.
- Terminal count: after 3 more rising edges -> count=0x00, tc=1.
- Wrap and priority:
  - With count=0x00 and enable=1, one more edge -> count=0xFF, tc=0.
  - Then load=1, enable=1, data_in=0xA0 -> count=0xA0, no decrement.
- Async reset mid-count:
  - Stimulus: count=0x40, enable=1; assert rst between clock edges.
  - Response: count=0x00 and tc=1 before the next rising edge; count holds 0 while rst=1.
